// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map and shared constants for the GPIO pad controller
package gpio_pkg;

   localparam logic [2:0] GPIO_DATAIN  = 3'd0;
   localparam logic [2:0] GPIO_DATAOUT = 3'd1;
   localparam logic [2:0] GPIO_OUTEN   = 3'd2;
   localparam logic [2:0] GPIO_ODMODE  = 3'd3;
   localparam logic [2:0] GPIO_INTEN   = 3'd4;
   localparam logic [2:0] GPIO_INTPOL  = 3'd5;
   localparam logic [2:0] GPIO_INTSTAT = 3'd6;

   localparam int GPIO_CNT_W = 4;

endpackage

// File: rtl/gpio_in_filter.sv
// rtl/gpio_in_filter.sv - one pin's synchroniser, debounce filter and edge pulses
module gpio_in_filter
   import gpio_pkg::*;
#(
   parameter int DBNC_CYC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam logic [GPIO_CNT_W-1:0] CNT_LAST = GPIO_CNT_W'(DBNC_CYC - 1);

   logic                  meta;
   logic                  sync;
   logic [GPIO_CNT_W-1:0] cnt;
   logic                  accept;

   assign accept = (sync != stable) && (cnt == CNT_LAST);
   assign rise   = accept & sync;
   assign fall   = accept & ~sync;

   // Idle level is the pull-up, so reset to 1 to avoid a false falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= 1'b1;
         sync   <= 1'b1;
         stable <= 1'b1;
         cnt    <= '0;
      end else begin
         meta <= pin;
         sync <= meta;
         if (sync == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sync;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// rtl/gpio_pad_ctrl.sv - register file, pad drive and interrupt logic for WIDTH GPIO pads
module gpio_pad_ctrl
   import gpio_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DBNC_CYC = 4
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             reg_sel,
   input  logic             reg_wr,
   input  logic [2:0]       reg_addr,
   input  logic [WIDTH-1:0] reg_wdata,
   output logic [WIDTH-1:0] reg_rdata,
   output logic [WIDTH-1:0] pad_pout,
   output logic [WIDTH-1:0] pad_pout_en,
   input  logic [WIDTH-1:0] pad_pin,
   output logic             irq
);

   logic [WIDTH-1:0] datain;
   logic [WIDTH-1:0] dataout;
   logic [WIDTH-1:0] outen;
   logic [WIDTH-1:0] odmode;
   logic [WIDTH-1:0] inten;
   logic [WIDTH-1:0] intpol;
   logic [WIDTH-1:0] intstat;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] rd_mux;
   logic             wr_en;
   logic             rd_en;

   for (genvar i = 0; i < WIDTH; i++) begin : g_flt
      gpio_in_filter #(
         .DBNC_CYC (DBNC_CYC)
      ) u_flt (
         .clk    (HCLK),
         .rst    (HRESET),
         .pin    (pad_pin[i]),
         .stable (datain[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

   // Open-drain pins never drive high; a 1 releases the pad to its pull-up.
   assign pad_pout    = dataout & ~odmode;
   assign pad_pout_en = outen & ~(odmode & dataout);

   assign wr_en    = reg_sel & reg_wr;
   assign rd_en    = reg_sel & ~reg_wr;
   assign edge_set = (rise & intpol) | (fall & ~intpol);
   assign w1c      = (wr_en && (reg_addr == GPIO_INTSTAT)) ? reg_wdata : '0;

   always_comb begin
      rd_mux = '0;
      case (reg_addr)
         GPIO_DATAIN:  rd_mux = datain;
         GPIO_DATAOUT: rd_mux = dataout;
         GPIO_OUTEN:   rd_mux = outen;
         GPIO_ODMODE:  rd_mux = odmode;
         GPIO_INTEN:   rd_mux = inten;
         GPIO_INTPOL:  rd_mux = intpol;
         GPIO_INTSTAT: rd_mux = intstat;
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dataout   <= '0;
         outen     <= '0;
         odmode    <= '0;
         inten     <= '0;
         intpol    <= '0;
         intstat   <= '0;
         reg_rdata <= '0;
         irq       <= 1'b0;
      end else begin
         if (wr_en) begin
            case (reg_addr)
               GPIO_DATAOUT: dataout <= reg_wdata;
               GPIO_OUTEN:   outen   <= reg_wdata;
               GPIO_ODMODE:  odmode  <= reg_wdata;
               GPIO_INTEN:   inten   <= reg_wdata;
               GPIO_INTPOL:  intpol  <= reg_wdata;
               default:      ;
            endcase
         end
         // A new edge outranks a simultaneous clear of the same bit.
         intstat <= (intstat & ~w1c) | edge_set;
         irq     <= |(intstat & inten);
         if (rd_en) begin
            reg_rdata <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb/tb_gpio_pad_ctrl.sv - directed self-checking bench for gpio_pad_ctrl
module tb_gpio_pad_ctrl;
   import gpio_pkg::*;

   logic       HCLK = 1'b0;
   logic       HRESET;
   logic       reg_sel;
   logic       reg_wr;
   logic [2:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic [7:0] pad_pout;
   logic [7:0] pad_pout_en;
   logic [7:0] pad_pin;
   logic       irq;

   int total  = 0;
   int passed = 0;

   gpio_pad_ctrl #(
      .WIDTH    (8),
      .DBNC_CYC (4)
   ) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .reg_sel     (reg_sel),
      .reg_wr      (reg_wr),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .reg_rdata   (reg_rdata),
      .pad_pout    (pad_pout),
      .pad_pout_en (pad_pout_en),
      .pad_pin     (pad_pin),
      .irq         (irq)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
      reg_sel   = 1'b1;
      reg_wr    = 1'b1;
      reg_addr  = a;
      reg_wdata = d;
      tick();
      reg_sel = 1'b0;
      reg_wr  = 1'b0;
   endtask

   task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
      reg_sel  = 1'b1;
      reg_wr   = 1'b0;
      reg_addr = a;
      tick();
      reg_sel = 1'b0;
      d = reg_rdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] rd;

      HRESET    = 1'b1;
      reg_sel   = 1'b0;
      reg_wr    = 1'b0;
      reg_addr  = '0;
      reg_wdata = '0;
      pad_pin   = 8'hFF;
      repeat (3) tick();
      HRESET = 1'b0;

      // Reset state
      check("rst_pout_en", pad_pout_en, 8'h00);
      check("rst_irq", irq, 1'b0);
      for (int a = 0; a < 8; a++) begin
         reg_read(3'(a), rd);
         check($sformatf("rst_rd_addr%0d", a), rd, (a == 0) ? 8'hFF : 8'h00);
      end

      // Pad drive: push-pull then open-drain on the low nibble
      reg_write(GPIO_DATAOUT, 8'hA5);
      reg_write(GPIO_OUTEN, 8'h0F);
      reg_write(GPIO_ODMODE, 8'h00);
      check("pp_pout", pad_pout, 8'hA5);
      check("pp_pout_en", pad_pout_en, 8'h0F);
      reg_write(GPIO_ODMODE, 8'h0F);
      check("od_pout", pad_pout, 8'hA0);
      check("od_pout_en", pad_pout_en, 8'h0A);
      reg_write(GPIO_DATAIN, 8'h00);
      reg_read(GPIO_DATAOUT, rd);
      check("rd_dataout", rd, 8'hA5);
      reg_read(GPIO_ODMODE, rd);
      check("rd_odmode", rd, 8'h0F);
      reg_read(GPIO_DATAIN, rd);
      check("datain_ro", rd, 8'hFF);

      // Three-cycle glitch on pin 2 is filtered out
      pad_pin[2] = 1'b0;
      repeat (3) tick();
      pad_pin[2] = 1'b1;
      repeat (8) tick();
      reg_read(GPIO_DATAIN, rd);
      check("glitch_datain", rd, 8'hFF);
      reg_read(GPIO_INTSTAT, rd);
      check("glitch_intstat", rd, 8'h00);

      // Clean falling edge on pin 2: accepted on the 6th edge, irq one edge later
      reg_write(GPIO_INTEN, 8'h04);
      pad_pin[2] = 1'b0;
      reg_sel  = 1'b1;
      reg_wr   = 1'b0;
      reg_addr = GPIO_DATAIN;
      repeat (6) tick();
      check("fall_datain_e6", reg_rdata, 8'hFF);
      check("fall_irq_e6", irq, 1'b0);
      tick();
      check("fall_datain_e7", reg_rdata, 8'hFB);
      check("fall_irq_e7", irq, 1'b1);
      reg_sel = 1'b0;
      reg_read(GPIO_INTSTAT, rd);
      check("fall_intstat", rd, 8'h04);
      reg_write(GPIO_INTSTAT, 8'h04);
      check("w1c_irq_lag", irq, 1'b1);
      tick();
      check("w1c_irq", irq, 1'b0);
      reg_read(GPIO_INTSTAT, rd);
      check("w1c_intstat", rd, 8'h00);

      // Rising edge on pin 5 collides with a W1C of the same bit
      reg_write(GPIO_INTPOL, 8'h20);
      pad_pin[5] = 1'b0;
      repeat (8) tick();
      reg_read(GPIO_INTSTAT, rd);
      check("p5_low_intstat", rd, 8'h00);
      pad_pin[5] = 1'b1;
      repeat (5) tick();
      reg_write(GPIO_INTSTAT, 8'h20);
      reg_read(GPIO_INTSTAT, rd);
      check("set_wins_intstat", rd, 8'h20);
      check("set_wins_irq", irq, 1'b0);
      reg_read(GPIO_DATAIN, rd);
      check("p5_datain", rd, 8'hFB);

      // Reset mid-debounce with pin 2 interrupt pending
      reg_write(GPIO_INTSTAT, 8'h20);
      reg_write(GPIO_INTPOL, 8'h24);
      pad_pin[2] = 1'b1;
      repeat (8) tick();
      reg_read(GPIO_INTSTAT, rd);
      check("pend_intstat", rd, 8'h04);
      check("pend_irq", irq, 1'b1);
      pad_pin[2] = 1'b0;
      repeat (3) tick();
      HRESET  = 1'b1;
      pad_pin = 8'hFF;
      tick();
      HRESET = 1'b0;
      check("mid_rst_irq", irq, 1'b0);
      check("mid_rst_pout_en", pad_pout_en, 8'h00);
      check("mid_rst_pout", pad_pout, 8'h00);
      check("mid_rst_rdata", reg_rdata, 8'h00);
      for (int a = 1; a < 7; a++) begin
         reg_read(3'(a), rd);
         check($sformatf("mid_rst_addr%0d", a), rd, 8'h00);
      end
      repeat (10) tick();
      reg_read(GPIO_DATAIN, rd);
      check("post_rst_datain", rd, 8'hFF);
      reg_read(GPIO_INTSTAT, rd);
      check("post_rst_intstat", rd, 8'h00);
      check("post_rst_irq", irq, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
